// File: rtl/unidade_acesso_memoria_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_acesso_memoria_pkg
//  Description : Shared types for the memory access unit: operation codes,
//                FSM state encodings and the alignment rule constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package unidade_acesso_memoria_pkg;

    // Load/store operation codes as presented on the Op input
    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    // Access sequencer states
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        LEITURA     = 3'd1,
        ESCRITA     = 3'd2,
        RMW_LE      = 3'd3,
        RMW_ESCREVE = 3'd4,
        CONCLUI     = 3'd5
    } estado_e;

    // Address low bits that must be zero for word and halfword accesses
    localparam logic [1:0] c_mascara_palavra = 2'b11;
    localparam logic [1:0] c_mascara_meia    = 2'b01;

    // True when the access size does not fit the low address bits
    function automatic logic desalinhado(input op_e op, input logic [1:0] lsb);
        logic res;
        res = 1'b0;
        case (op)
            OP_LW, OP_SW:         res = ((lsb & c_mascara_palavra) != 2'b00);
            OP_LH, OP_LHU, OP_SH: res = ((lsb & c_mascara_meia) != 2'b00);
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the five load operations
    function automatic logic eh_carga(input op_e op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_acesso_memoria_alinhador_dados.sv
`default_nettype none
// ============================================================================
//  Module      : alinhador_dados
//  Description : Combinational lane logic: extracts and extends a load lane
//                from a memory word, and merges a byte/half store into a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module alinhador_dados
    import unidade_acesso_memoria_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_palavra_lida,
    input  logic [31:0] i_dados_escrita,
    input  logic [31:0] i_palavra_merge,
    output logic [31:0] o_dados_carga,
    output logic [31:0] o_palavra_merge
);

    op_e         w_op;
    logic [4:0]  w_desloc_byte;
    logic [4:0]  w_desloc_meia;
    logic [31:0] w_palavra_desloc_b;
    logic [31:0] w_palavra_desloc_h;
    logic [7:0]  w_byte;
    logic [15:0] w_meia;
    logic [31:0] w_mascara_byte;
    logic [31:0] w_mascara_meia;

    assign w_op = op_e'(i_op);

    // Little-endian lane positions: byte k at 8k, half h at 16h
    always_comb begin
        w_desloc_byte      = {i_lsb, 3'b000};
        w_desloc_meia      = {i_lsb[1], 4'b0000};
        w_palavra_desloc_b = i_palavra_lida >> w_desloc_byte;
        w_palavra_desloc_h = i_palavra_lida >> w_desloc_meia;
        w_byte             = w_palavra_desloc_b[7:0];
        w_meia             = w_palavra_desloc_h[15:0];
        w_mascara_byte     = 32'h0000_00FF << w_desloc_byte;
        w_mascara_meia     = 32'h0000_FFFF << w_desloc_meia;
    end

    // Load result: sign- or zero-extend the selected lane
    always_comb begin
        o_dados_carga = i_palavra_lida;
        case (w_op)
            OP_LB:   o_dados_carga = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_dados_carga = {24'h000000, w_byte};
            OP_LH:   o_dados_carga = {{16{w_meia[15]}}, w_meia};
            OP_LHU:  o_dados_carga = {16'h0000, w_meia};
            default: o_dados_carga = i_palavra_lida;
        endcase
    end

    // Store merge: replace only the target lane of the previously read word
    always_comb begin
        o_palavra_merge = i_palavra_merge;
        case (w_op)
            OP_SB:   o_palavra_merge = (i_palavra_merge & ~w_mascara_byte) |
                                       ({24'h000000, i_dados_escrita[7:0]} << w_desloc_byte);
            OP_SH:   o_palavra_merge = (i_palavra_merge & ~w_mascara_meia) |
                                       ({16'h0000, i_dados_escrita[15:0]} << w_desloc_meia);
            default: o_palavra_merge = i_palavra_merge;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_acesso_memoria.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_acesso_memoria
//  Description : Load/store sequencer between the ALU and a word-wide data
//                memory; handles sub-word loads and read-modify-write stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_acesso_memoria
    import unidade_acesso_memoria_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Endereco,
    input  logic [31:0] DadosEscrita,
    output logic [31:0] DadosLidos,
    output logic        Pronto,
    output logic        Ocupado,
    output logic        ErroAlinhamento,
    output logic [31:0] MemEndereco,
    output logic [31:0] MemDadosEscrita,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemDadosLidos
);

    estado_e     r_estado;
    estado_e     w_proximo;
    op_e         r_op;
    logic [31:0] r_endereco;
    logic [31:0] r_dados;
    logic [31:0] r_merge;
    logic        r_erro;
    logic [31:0] r_dados_lidos;

    op_e         w_op_entrada;
    logic        w_end_ativo;
    logic [31:0] w_dados_carga;
    logic [31:0] w_palavra_merge;

    assign w_op_entrada = op_e'(Op);

    alinhador_dados u_alinhador (
        .i_op            (r_op),
        .i_lsb           (r_endereco[1:0]),
        .i_palavra_lida  (MemDadosLidos),
        .i_dados_escrita (r_dados),
        .i_palavra_merge (r_merge),
        .o_dados_carga   (w_dados_carga),
        .o_palavra_merge (w_palavra_merge)
    );

    // State register; reset aborts any access immediately
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_estado <= OCIOSO;
        else        r_estado <= w_proximo;
    end

    // Request latch, load result and RMW merge word; memory data is only
    // sampled in the states that drive MemRead
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_op          <= OP_LB;
            r_endereco    <= 32'h0;
            r_dados       <= 32'h0;
            r_merge       <= 32'h0;
            r_erro        <= 1'b0;
            r_dados_lidos <= 32'h0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (Req) begin
                        r_op       <= w_op_entrada;
                        r_endereco <= Endereco;
                        r_dados    <= DadosEscrita;
                        r_erro     <= desalinhado(w_op_entrada, Endereco[1:0]);
                    end
                end
                LEITURA: r_dados_lidos <= w_dados_carga;
                RMW_LE:  r_merge       <= MemDadosLidos;
                default: ;
            endcase
        end
    end

    // Next state and Moore outputs of the memory interface
    always_comb begin
        w_proximo       = r_estado;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        MemDadosEscrita = 32'h0;
        w_end_ativo     = 1'b0;
        Pronto          = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (Req) begin
                    if (desalinhado(w_op_entrada, Endereco[1:0])) w_proximo = CONCLUI;
                    else if (eh_carga(w_op_entrada))              w_proximo = LEITURA;
                    else if (w_op_entrada == OP_SW)               w_proximo = ESCRITA;
                    else                                          w_proximo = RMW_LE;
                end
            end
            LEITURA: begin
                MemRead     = 1'b1;
                w_end_ativo = 1'b1;
                w_proximo   = CONCLUI;
            end
            ESCRITA: begin
                MemWrite        = 1'b1;
                MemDadosEscrita = r_dados;
                w_end_ativo     = 1'b1;
                w_proximo       = CONCLUI;
            end
            RMW_LE: begin
                MemRead     = 1'b1;
                w_end_ativo = 1'b1;
                w_proximo   = RMW_ESCREVE;
            end
            RMW_ESCREVE: begin
                MemWrite        = 1'b1;
                MemDadosEscrita = w_palavra_merge;
                w_end_ativo     = 1'b1;
                w_proximo       = CONCLUI;
            end
            CONCLUI: begin
                Pronto    = 1'b1;
                w_proximo = OCIOSO;
            end
            default: w_proximo = OCIOSO;
        endcase
    end

    assign MemEndereco     = w_end_ativo ? {r_endereco[31:2], 2'b00} : 32'h0;
    assign Ocupado         = (r_estado != OCIOSO);
    assign ErroAlinhamento = Pronto & r_erro;
    assign DadosLidos      = r_dados_lidos;

endmodule
`default_nettype wire
